// File: rtl/aes256_round_ctrl_if.sv
// Block-side and datapath-side signals of the AES-256 round sequencer.
// The slave modport is the controller's view; master is the surrounding logic.
interface aes256_round_ctrl_if;
    logic         key_valid;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [127:0] rf_state;
    logic         rf_last;
    logic [127:0] rf_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport slave (
        input  key_valid, in_valid, in_data, rk_data, rf_out, out_ready,
        output in_ready, rk_idx, rf_state, rf_last, out_valid, out_data, busy
    );

    modport master (
        output key_valid, in_valid, in_data, rk_data, rf_out, out_ready,
        input  in_ready, rk_idx, rf_state, rf_last, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes256_round_ctrl.sv
// Iterative AES-256 round sequencer: initial key add, then one shared round
// per clock for rounds 1..NR, ciphertext held in the state register.
module aes256_round_ctrl #(
    parameter int NR = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    aes256_round_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_t         fsm_q;
    logic [3:0]   rnd_q;
    logic [127:0] state_q;
    logic [127:0] state_d;
    logic         busy_q;
    logic         out_valid_q;
    logic         rf_last_q;
    logic         accept;

    // key_valid only matters at acceptance; a block in flight runs to completion
    assign accept = (fsm_q == IDLE) && bus.in_valid && bus.key_valid;

    always_comb begin
        state_d = state_q;
        case (fsm_q)
            IDLE:    if (accept) state_d = bus.in_data ^ bus.rk_data;
            ROUND:   state_d = bus.rf_out ^ bus.rk_data;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // rf_last is precomputed one cycle ahead so it is a plain flop output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            rnd_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            rf_last_q   <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        fsm_q     <= ROUND;
                        rnd_q     <= 4'd1;
                        busy_q    <= 1'b1;
                        rf_last_q <= (NR_L == 4'd1);
                    end
                end
                ROUND: begin
                    if (rnd_q == NR_L) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                        rf_last_q   <= 1'b0;
                    end else begin
                        rnd_q     <= rnd_q + 4'd1;
                        rf_last_q <= ((rnd_q + 4'd1) == NR_L);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm_q       <= IDLE;
                        rnd_q       <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    rnd_q       <= '0;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    rf_last_q   <= 1'b0;
                end
            endcase
        end
    end

    // rnd is 0 throughout IDLE, so it doubles as the key index there
    assign bus.in_ready  = (fsm_q == IDLE) && bus.key_valid;
    assign bus.rk_idx    = rnd_q;
    assign bus.rf_state  = state_q;
    assign bus.rf_last   = rf_last_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = state_q;
    assign bus.busy      = busy_q;

    a_rnd_range: assert property (@(posedge clk) disable iff (!rst_n)
        rnd_q <= NR_L);
    a_idle_rnd: assert property (@(posedge clk) disable iff (!rst_n)
        (fsm_q == IDLE) |-> (rnd_q == 4'd0));
    a_rf_last: assert property (@(posedge clk) disable iff (!rst_n)
        rf_last_q == ((fsm_q == ROUND) && (rnd_q == NR_L)));
    a_flags: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q == (fsm_q == DONE)) && (busy_q == (fsm_q != IDLE)));
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(state_q)));

endmodule

// File: tb/tb_aes256_round_ctrl.sv
// Self-checking bench: behavioural round function and key table around the
// sequencer, fixed vectors, corner-case sequences and random back-to-back blocks.
module tb_aes256_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes256_round_ctrl_if bus();

    aes256_round_ctrl #(.NR(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
        bit           stray;
    } vec_t;

    vec_t         vecs[4];
    logic [7:0]   sbox_t[256];
    logic [127:0] rk_tab[16];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   b;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
                o[127 - 8 * (r + 4 * c) -: 8] = sbox_t[b];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        return last ? sub_shift(s) : mix_cols(sub_shift(s));
    endfunction

    function automatic logic [127:0] round_key(input logic [255:0] key, input int r);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    function automatic logic [127:0] aes256_ref(input logic [255:0] key, input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ round_key(key, 0);
        for (int r = 1; r <= 14; r++) s = aes_round(s, r == 14) ^ round_key(key, r);
        return s;
    endfunction

    assign bus.rk_data = rk_tab[bus.rk_idx];
    assign bus.rf_out  = aes_round(bus.rf_state, bus.rf_last);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic load_key(input logic [255:0] key);
        for (int r = 0; r < 15; r++) rk_tab[r] = round_key(key, r);
        rk_tab[15] = '0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered and left just after a falling edge.
    task automatic run_block(input logic [255:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int hold, input bit stray,
                             output int acc);
        load_key(key);
        bus.key_valid = 1'b1;
        bus.in_data   = pt;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        acc = cyc;
        #1;
        chk("in_ready_idle", 128'(bus.in_ready), 128'd1);
        chk("rk_idx_accept", 128'(bus.rk_idx), 128'd0);
        @(posedge clk);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k <= 14) begin
                chk("rk_idx_step", 128'(bus.rk_idx), 128'(k));
                chk("rf_last", 128'(bus.rf_last), 128'(k == 14));
                chk("out_valid_early", 128'(bus.out_valid), 128'd0);
                chk("busy_round", 128'(bus.busy), 128'd1);
                chk("in_ready_round", 128'(bus.in_ready), 128'd0);
            end else begin
                chk("out_valid_lat14", 128'(bus.out_valid), 128'd1);
                chk("ciphertext", bus.out_data, ct);
                chk("in_ready_done", 128'(bus.in_ready), 128'd0);
                chk("rf_last_done", 128'(bus.rf_last), 128'd0);
            end
            if (k == 1) begin
                bus.in_valid = stray;
                if (stray) bus.in_data = rand128();
            end
            if (k == 15) bus.in_valid = 1'b0;
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 128'(bus.out_valid), 128'd1);
            chk("hold_data", bus.out_data, ct);
            chk("hold_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("idle_out_valid", 128'(bus.out_valid), 128'd0);
        chk("idle_busy", 128'(bus.busy), 128'd0);
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);
    endtask

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        logic [255:0] rkey;
        logic [127:0] rpt;
        logic         seen;
        logic [7:0]   inv;

        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[v] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;

        vecs[0] = '{C3_KEY, C3_PT, C3_CT, 0, 1'b0};
        vecs[1] = '{C3_KEY, C3_PT, C3_CT, 20, 1'b0};
        vecs[2] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    128'h6bc1bee22e409f96e93d7e117393172a,
                    128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 0, 1'b1};
        vecs[3] = '{C3_KEY, C3_PT, C3_CT, 2, 1'b1};

        bus.key_valid = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_out_data", bus.out_data, 128'd0);
        chk("rst_rf_state", bus.rf_state, 128'd0);
        chk("rst_rk_idx", 128'(bus.rk_idx), 128'd0);
        chk("rst_rf_last", 128'(bus.rf_last), 128'd0);
        chk("rst_in_ready_kv0", 128'(bus.in_ready), 128'd0);
        bus.key_valid = 1'b1;
        #1;
        chk("rst_in_ready_kv1", 128'(bus.in_ready), 128'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_block(vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].hold, vecs[i].stray, acc);

        // Key gating: plaintext offered without a valid schedule is never taken.
        bus.key_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = rand128();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gate_in_ready", 128'(bus.in_ready), 128'd0);
            chk("gate_busy", 128'(bus.busy), 128'd0);
        end
        bus.in_valid  = 1'b0;
        bus.key_valid = 1'b1;

        // Reset at round 7: everything returns to reset values, no output pulse.
        load_key(C3_KEY);
        bus.in_data  = C3_PT;
        bus.in_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        chk("mid_rk_idx7", 128'(bus.rk_idx), 128'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_rst_busy", 128'(bus.busy), 128'd0);
        chk("mid_rst_out_data", bus.out_data, 128'd0);
        chk("mid_rst_rf_state", bus.rf_state, 128'd0);
        chk("mid_rst_rk_idx", 128'(bus.rk_idx), 128'd0);
        chk("mid_rst_rf_last", 128'(bus.rf_last), 128'd0);
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        chk("post_rst_quiet", 128'(seen), 128'd0);
        run_block(C3_KEY, C3_PT, C3_CT, 0, 1'b0, acc);

        // Back-to-back random blocks with out_ready held high.
        prev = 0;
        for (int b = 0; b < 8; b++) begin
            rkey = {rand128(), rand128()};
            rpt  = rand128();
            run_block(rkey, rpt, aes256_ref(rkey, rpt), 0, 1'b0, acc);
            if (b > 0) chk("accept_spacing", 128'(acc - prev), 128'd16);
            prev = acc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes256_round_ctrl.md
# aes256_round_ctrl

Iterative round sequencer for the AES-256 encryption path. Accepts one 128-bit plaintext block, applies the initial AddRoundKey, then steps the shared single-round datapath (SubBytes, ShiftRows, `mixcolumn`) through rounds 1..14, one round per clock. After round 14 it presents the ciphertext. It sits between the block-level valid/ready interface and the combinational round function plus the expanded-key table.

## Interface

**Parameters**

- `NR`, 14, number of rounds; fixed for AES-256; sizes the round counter (4 bits).

**Ports**

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  expanded-key table holds a complete, stable schedule.
- `in_valid`  in  1  plaintext offered.
- `in_ready`  out  1  controller can accept plaintext.
- `in_data`  in  128  plaintext, byte 0 in [127:120].
- `rk_idx`  out  4  round-key index to the key table.
- `rk_data`  in  128  round key `rk_idx`, combinational (same-cycle) from the table.
- `rf_state`  out  128  state fed to the round function.
- `rf_last`  out  1  final round: the round function bypasses MixColumns.
- `rf_out`  in  128  round-function result (no key add), combinational.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer accepts ciphertext.
- `out_data`  out  128  ciphertext; this is the state register.
- `busy`  out  1  high in ROUND and DONE.

## Operation

**State machine:** IDLE, ROUND, DONE.

**IDLE**
- `in_ready = key_valid`.
- `rk_idx = 0`.
- On `in_valid & in_ready`:
  - `state <= in_data ^ rk_data` (round key 0).
  - `rnd <= 1`.
  - Go to ROUND.

**ROUND**
- `rk_idx = rnd`, `rf_state = state`, `rf_last = (rnd == NR)`.
- Each cycle, `state <= rf_out ^ rk_data`.
- If `rnd == NR`, go to DONE; otherwise `rnd <= rnd + 1`.

**DONE**
- `out_valid = 1`, `out_data = state`.
- On `out_ready`, go to IDLE and set `rnd <= 0`.
- `state` holds its value until the next acceptance.

**Width and arithmetic rules**
- Key add is a bitwise 128-bit XOR.
- `rnd` is 4-bit, range 0..14, and never wraps past 14.

**Fixed rules**
- `in_ready` is 0 in ROUND and DONE. There is no accept in the same cycle as an output handshake; a new block is accepted at the earliest one cycle after the `out_ready` handshake.
- `key_valid` is sampled only at acceptance. Deasserting it mid-block does not stall or abort the block; table stability during a block is the key-expansion owner's obligation.
- `in_data` and `in_valid` are ignored outside IDLE.
- `rf_state` = `state` and `rf_last` = 0 outside ROUND.
- `out_data` always drives `state`; it is meaningful only while `out_valid` is high.

## Timing

**Reset values:** FSM = IDLE, `rnd` = 0, `state` = 0. Hence:
- `out_valid` = 0, `busy` = 0, `out_data` = 0, `rf_state` = 0.
- `rk_idx` = 0, `rf_last` = 0.
- `in_ready` = `key_valid`.

**Reset while active:** asserting `rst_n` low in any state immediately forces the reset values. The in-flight block is lost and no `out_valid` pulse is produced.

**Latency**
- Acceptance edge E0.
- Round r is written at edge E0 + r.
- `out_valid` rises after E0 + 14, i.e. 14 cycles after acceptance.
- With `out_ready` held high, a new block is accepted at the earliest at E0 + 16; throughput is 1 block per 16 cycles.

**Output backpressure:** `out_valid` and `out_data` stay stable while `out_ready` is low, for any number of cycles.

**Control path:** `rk_idx` and `rf_last` are decoded from registered state and `rnd` only. There is no combinational path from `in_valid` or `out_ready` to `rk_idx` or `rf_state`.

## Test plan

The bench instantiates the real round function and key-expansion table.

- **FIPS-197 C.3 vector.** Key 000102…1f, plaintext 00112233445566778899aabbccddeeff → `out_data` = 8ea2b7ca516745bfeafc49904b496089, with `out_valid` first high exactly 14 cycles after acceptance.
- **Sequencing trace.** During that block, `rk_idx` steps 0, 1, …, 14 on consecutive cycles, and `rf_last` is high only on the cycle with `rk_idx` = 14.
- **Output backpressure.** Hold `out_ready` = 0 for 20 cycles after `out_valid` → `out_data` stable, `in_ready` = 0. Raise `out_ready` → IDLE next cycle, then accept the next block and produce the correct ciphertext.
- **Key gating and stray input.** `key_valid` = 0 with `in_valid` = 1 → no acceptance, `busy` = 0. Assert `in_valid` during ROUND with different data → result unchanged.
- **Reset mid-block.** Assert `rst_n` low at round 7 → all outputs at reset values, no `out_valid`. After release, a fresh block produces the C.3 ciphertext.
- **Back-to-back blocks.** 8 consecutive blocks with random key/plaintext and `out_ready` held high → each matches the software AES-256 model; acceptance spacing is exactly 16 cycles.
